latch_readback: RTL and testbench

Readback engine for the configuration latch array.
- Lets the RISC-V read back any single latch row, or scan all rows and fold them into one XOR checksum, through the same 32-bit/3-bit-address register window that the loader uses.
- Drives one-hot row-select lines into the array's read mux and captures row data into a WIDTH-bit capture register.
- Exposes the capture register as two 32-bit words.

---
 rtl/prism_cfg_pkg.sv | 38 +++
 rtl/latch_readback.sv | 151 +++++++++++++++
 tb/tb_latch_readback.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/prism_cfg_pkg.sv
// ---------------------------------------------------------------------------
// prism_cfg_pkg
// Shared definitions for the configuration latch array loader and readback
// engine: FSM state encoding, register-window addresses, row-index width
// derivation and the one-hot row decode.
// ---------------------------------------------------------------------------
package prism_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SELECT  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [2:0] ADDR_LO = 3'h0;
    localparam logic [2:0] ADDR_HI = 3'h4;

    // Number of index bits needed to address 'depth' rows (depth 1..32).
    function automatic int idx_bits(input int depth);
        if (depth > 16)
            return 5;
        else if (depth > 8)
            return 4;
        else
            return 3;
    endfunction

    // One-hot decode of a row index. Indices at or beyond 'depth' decode to
    // all-zero so a stray index can never select a row.
    function automatic logic [31:0] onehot_row(input logic [4:0] idx, input int depth);
        logic [31:0] sel;
        sel = '0;
        if (int'(idx) < depth)
            sel[idx] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/latch_readback.sv
// ---------------------------------------------------------------------------
// latch_readback
// Readback engine for the configuration latch array. A CPU register write
// either reads back a single row or scans every row and folds them into one
// XOR checksum. Each row access takes two cycles: SELECT lets the array read
// mux settle, CAPTURE registers its output.
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   read_req  one-cycle command strobe (accepted only when idle)
//   data_in   command data; low IDX_BITS bits are the row for a single read
//   address   3'h0 = single read / low word, 3'h4 = scan / high word
//   row_data  read-mux output of the latch array
//   row_sel   registered one-hot row select to the array read mux
//   data_out  capture register word selected by address
//   busy      high whenever the engine is not idle
//   done      one-cycle pulse in the first idle cycle after an operation
// ---------------------------------------------------------------------------
module latch_readback
    import prism_cfg_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             read_req,
    input  logic [31:0]      data_in,
    input  logic [2:0]       address,
    input  logic [WIDTH-1:0] row_data,
    output logic [DEPTH-1:0] row_sel,
    output logic [31:0]      data_out,
    output logic             busy,
    output logic             done
);

    localparam int IDX_BITS = idx_bits(DEPTH);
    localparam logic [IDX_BITS-1:0] LAST_ROW = IDX_BITS'(DEPTH - 1);

    state_t               state_q,   state_d;
    logic [IDX_BITS-1:0]  index_q,   index_d;
    logic [WIDTH-1:0]     capture_q, capture_d;
    logic                 scan_q,    scan_d;
    logic                 done_q,    done_d;
    logic [DEPTH-1:0]     row_sel_q, row_sel_d;
    logic [31:0]          sel_wide;
    logic                 in_range;
    logic [63:0]          capture_ext;
    logic                 unused_data;

    // Only a single read can carry an out-of-range index; a scan always
    // starts at DEPTH-1 and counts down.
    assign in_range = (int'(index_q) < DEPTH);

    // NOTE: every variable driven here gets a default first, so no path
    // through the case statement leaves a value unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        capture_d = capture_q;
        scan_d    = scan_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (read_req) begin
                    if (address == ADDR_LO) begin
                        index_d = data_in[IDX_BITS-1:0];
                        scan_d  = 1'b0;
                        state_d = SELECT;
                    end else if (address == ADDR_HI) begin
                        index_d   = LAST_ROW;
                        capture_d = '0;
                        scan_d    = 1'b1;
                        state_d   = SELECT;
                    end
                end
            end

            SELECT: begin
                state_d = CAPTURE;
            end

            CAPTURE: begin
                if (!scan_q) begin
                    capture_d = in_range ? row_data : '0;
                    state_d   = IDLE;
                    done_d    = 1'b1;
                end else begin
                    capture_d = capture_q ^ row_data;
                    if (index_q == '0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        index_d = index_q - IDX_BITS'(1);
                        state_d = SELECT;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // row_sel is registered from the next state and index so that it is
    // already valid in the first SELECT cycle and drops on return to IDLE.
    assign sel_wide  = onehot_row(5'(index_d), DEPTH);
    assign row_sel_d = (state_d != IDLE) ? sel_wide[DEPTH-1:0] : '0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours, independent of ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            index_q   <= '0;
            capture_q <= '0;
            scan_q    <= 1'b0;
            done_q    <= 1'b0;
            row_sel_q <= '0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            capture_q <= capture_d;
            scan_q    <= scan_d;
            done_q    <= done_d;
            row_sel_q <= row_sel_d;
        end
    end

    // Zero-extend so the high word is well defined for any WIDTH in 33..64.
    assign capture_ext = 64'(capture_q);

    always_comb begin
        case (address)
            ADDR_LO: data_out = capture_ext[31:0];
            ADDR_HI: data_out = capture_ext[63:32];
            default: data_out = '0;
        endcase
    end

    assign row_sel = row_sel_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

    // Upper command bits are not part of the row index.
    assign unused_data = &{1'b0, data_in[31:IDX_BITS]};

endmodule

// File: tb/tb_latch_readback.sv
// ---------------------------------------------------------------------------
// tb_latch_readback
// Directed bench for latch_readback. Instance A uses the default 8x64 array;
// instance B uses a 6x40 array to exercise out-of-range indices and the
// zero-extended high word. Each array is modelled as a row table behind a
// one-hot mux that returns a garbage pattern when no row is selected.
// ---------------------------------------------------------------------------
module tb_latch_readback;

    logic        clk;
    logic        rst_n;
    logic        req_a;
    logic        req_b;
    logic [31:0] data_in;
    logic [2:0]  address;

    logic [63:0] rows_a [8];
    logic [39:0] rows_b [6];
    logic [63:0] row_data_a;
    logic [39:0] row_data_b;
    logic [7:0]  row_sel_a;
    logic [5:0]  row_sel_b;
    logic [31:0] data_out_a;
    logic [31:0] data_out_b;
    logic        busy_a, busy_b;
    logic        done_a, done_b;

    int n_vec  = 0;
    int n_miss = 0;

    latch_readback #(.DEPTH(8), .WIDTH(64)) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .read_req (req_a),
        .data_in  (data_in),
        .address  (address),
        .row_data (row_data_a),
        .row_sel  (row_sel_a),
        .data_out (data_out_a),
        .busy     (busy_a),
        .done     (done_a)
    );

    latch_readback #(.DEPTH(6), .WIDTH(40)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .read_req (req_b),
        .data_in  (data_in),
        .address  (address),
        .row_data (row_data_b),
        .row_sel  (row_sel_b),
        .data_out (data_out_b),
        .busy     (busy_b),
        .done     (done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        row_data_a = 64'hBAD0_BAD0_BAD0_BAD0;
        for (int i = 0; i < 8; i++)
            if (row_sel_a[i]) row_data_a = rows_a[i];
    end

    always_comb begin
        row_data_b = 40'hBA_DBAD_BAD0;
        for (int i = 0; i < 6; i++)
            if (row_sel_b[i]) row_data_b = rows_b[i];
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_words_a(input string tag, input logic [63:0] exp);
        address = 3'h0;
        #1 check({tag, "_lo"}, 64'(data_out_a), 64'(exp[31:0]));
        address = 3'h4;
        #1 check({tag, "_hi"}, 64'(data_out_a), 64'(exp[63:32]));
    endtask

    // Single read on instance A; returns positioned in the done cycle.
    task automatic read_a(input int row, input logic [63:0] exp);
        logic [7:0] sel;
        sel = 8'h01 << row;
        @(negedge clk);
        address = 3'h0;
        data_in = 32'(row);
        req_a   = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        check("rd_sel1", 64'(row_sel_a), 64'(sel));
        check("rd_busy1", 64'(busy_a), 64'd1);
        @(negedge clk);
        check("rd_sel2", 64'(row_sel_a), 64'(sel));
        check("rd_busy2", 64'(busy_a), 64'd1);
        check("rd_done2", 64'(done_a), 64'd0);
        @(negedge clk);
        check("rd_done", 64'(done_a), 64'd1);
        check("rd_idle", 64'(busy_a), 64'd0);
        check("rd_sel_off", 64'(row_sel_a), 64'd0);
        check_words_a("rd_data", exp);
    endtask

    task automatic run_scan(input bit collide);
        logic [7:0] sel;
        @(negedge clk);
        address = 3'h4;
        req_a   = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            req_a = 1'b0;
            sel = 8'h80 >> (k / 2);
            check("scan_sel", 64'(row_sel_a), 64'(sel));
            check("scan_busy", 64'(busy_a), 64'd1);
            check("scan_done", 64'(done_a), 64'd0);
            if (collide && k == 5) begin
                req_a   = 1'b1;
                address = 3'h0;
                data_in = 32'd2;
            end
        end
        @(negedge clk);
        check("scan_end_done", 64'(done_a), 64'd1);
        check("scan_end_busy", 64'(busy_a), 64'd0);
        check("scan_end_sel", 64'(row_sel_a), 64'd0);
        check_words_a("scan_sum", 64'h8888_8888_8888_8888);
        @(negedge clk);
        check("scan_no_extra_done", 64'(done_a), 64'd0);
        check("scan_stays_idle", 64'(busy_a), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        req_a   = 1'b0;
        req_b   = 1'b0;
        data_in = '0;
        address = 3'h0;
        for (int i = 0; i < 8; i++)
            rows_a[i] = 64'h1111_1111_1111_1111 * 64'(i + 1);
        for (int i = 0; i < 6; i++)
            rows_b[i] = 40'h11_1111_1111 * 40'(i + 1);

        // Reset held with random command traffic.
        repeat (4) begin
            @(negedge clk);
            req_a   = 1'($urandom);
            req_b   = 1'($urandom);
            data_in = $urandom;
            address = 3'($urandom);
        end
        @(negedge clk);
        req_a = 1'b0;
        req_b = 1'b0;
        check("rst_sel_a", 64'(row_sel_a), 64'd0);
        check("rst_busy_a", 64'(busy_a), 64'd0);
        check("rst_done_a", 64'(done_a), 64'd0);
        check("rst_sel_b", 64'(row_sel_b), 64'd0);
        check("rst_busy_b", 64'(busy_b), 64'd0);
        check("rst_done_b", 64'(done_b), 64'd0);
        address = 3'h0;
        #1 check("rst_lo_a", 64'(data_out_a), 64'd0);
        check("rst_lo_b", 64'(data_out_b), 64'd0);
        address = 3'h4;
        #1 check("rst_hi_a", 64'(data_out_a), 64'd0);
        check("rst_hi_b", 64'(data_out_b), 64'd0);
        rst_n = 1'b1;

        // Single read of row 5.
        rows_a[5] = 64'hDEAD_BEEF_0123_4567;
        read_a(5, 64'hDEAD_BEEF_0123_4567);

        // Command arriving in the done cycle is accepted.
        address = 3'h0;
        data_in = 32'd3;
        req_a   = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        check("b2b_busy", 64'(busy_a), 64'd1);
        check("b2b_sel", 64'(row_sel_a), 64'h08);
        @(negedge clk);
        @(negedge clk);
        check("b2b_done", 64'(done_a), 64'd1);
        check_words_a("b2b_data", 64'h4444_4444_4444_4444);

        // Full scan, then again with a colliding single-read request.
        rows_a[5] = 64'h6666_6666_6666_6666;
        run_scan(1'b0);
        run_scan(1'b1);

        // Instance B: in-range read, then out-of-range index.
        rows_b[5] = 40'hA5_1234_5678;
        @(negedge clk);
        address = 3'h0;
        data_in = 32'd5;
        req_b   = 1'b1;
        @(negedge clk);
        req_b = 1'b0;
        check("b_sel1", 64'(row_sel_b), 64'h20);
        check("b_busy1", 64'(busy_b), 64'd1);
        @(negedge clk);
        check("b_sel2", 64'(row_sel_b), 64'h20);
        @(negedge clk);
        check("b_done", 64'(done_b), 64'd1);
        check("b_idle", 64'(busy_b), 64'd0);
        address = 3'h0;
        #1 check("b_lo", 64'(data_out_b), 64'h1234_5678);
        address = 3'h4;
        #1 check("b_hi_zext", 64'(data_out_b), 64'h0000_00A5);
        address = 3'h2;
        #1 check("b_other_addr", 64'(data_out_b), 64'd0);

        @(negedge clk);
        address = 3'h0;
        data_in = 32'd7;
        req_b   = 1'b1;
        @(negedge clk);
        req_b = 1'b0;
        check("oor_sel1", 64'(row_sel_b), 64'd0);
        check("oor_busy1", 64'(busy_b), 64'd1);
        @(negedge clk);
        check("oor_sel2", 64'(row_sel_b), 64'd0);
        check("oor_busy2", 64'(busy_b), 64'd1);
        check("oor_done2", 64'(done_b), 64'd0);
        @(negedge clk);
        check("oor_done", 64'(done_b), 64'd1);
        check("oor_idle", 64'(busy_b), 64'd0);
        address = 3'h0;
        #1 check("oor_lo", 64'(data_out_b), 64'd0);
        address = 3'h4;
        #1 check("oor_hi", 64'(data_out_b), 64'd0);

        // Reset during the third row of a scan.
        @(negedge clk);
        address = 3'h4;
        req_a   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            req_a = 1'b0;
        end
        check("mid_sel_before", 64'(row_sel_a), 64'h20);
        #2 rst_n = 1'b0;
        #1 check("mid_rst_sel", 64'(row_sel_a), 64'd0);
        check("mid_rst_busy", 64'(busy_a), 64'd0);
        check("mid_rst_done", 64'(done_a), 64'd0);
        address = 3'h0;
        #1 check("mid_rst_lo", 64'(data_out_a), 64'd0);
        address = 3'h4;
        #1 check("mid_rst_hi", 64'(data_out_a), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        read_a(1, 64'h2222_2222_2222_2222);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
